// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encoding, trigger modes and depth helper for la_capture
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4,
        ST_READ = 3'd5
    } la_state_e;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

    function automatic int unsigned la_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/la_capture_ram.sv
// rtl/la_capture_ram.sv - simple dual-port sample RAM, one clock, synchronous read
module la_capture_ram
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = la_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture.sv
// rtl/la_capture.sv - logic-analyzer capture engine: circular buffer, masked trigger, skid-buffered readout
module la_capture
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  trig_edge,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic                  rd_start,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr
);
    localparam int            AW       = ADDR_WIDTH;
    localparam logic [AW:0]   DEPTH    = (AW+1)'(la_depth(AW));
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    la_state_e             r_state, w_state_next;
    logic [AW-1:0]         r_wr_ptr, r_trig_addr, r_rd_ptr;
    logic [AW:0]           r_pre_cnt, r_post_cnt, r_rd_cnt;
    logic                  r_prev_match, r_triggered;
    logic                  r_ram_vld, r_ram_last;
    logic [DATA_WIDTH-1:0] r_q_data [2];
    logic [1:0]            r_q_last;
    logic [1:0]            r_q_cnt;

    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_match, w_trig, w_arm_ok, w_rd_go, w_we, w_pop;
    logic                  w_issue, w_issue_last, w_push_idx;
    logic [AW:0]           w_pre_next, w_post_next, w_post_target;
    logic [AW-1:0]         w_start_addr, w_rd_addr;
    logic [1:0]            w_occ;

    assign w_match       = ((sample_data ^ trig_value) & trig_mask) == '0;
    assign w_trig        = sample_valid & w_match & ((trig_edge == TRIG_LEVEL) | ~r_prev_match);
    assign w_arm_ok      = arm & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_rd_go       = rd_start & ~abort & ~arm & (r_state == ST_DONE);
    assign w_we          = sample_valid & ~abort &
                           ((r_state == ST_PRE) | (r_state == ST_WAIT) | (r_state == ST_POST));
    assign w_pre_next    = r_pre_cnt + {{AW{1'b0}}, sample_valid};
    assign w_post_next   = r_post_cnt + CNT_ONE;
    assign w_post_target = DEPTH - {1'b0, pre_depth};

    // Words held in the skid plus the one in the RAM read stage; a read is
    // issued only when it is guaranteed a slot even if the sink stalls next cycle.
    assign w_pop        = rd_valid & rd_ready;
    assign w_occ        = r_q_cnt + {1'b0, r_ram_vld} - {1'b0, w_pop};
    assign w_start_addr = r_trig_addr - pre_depth;
    assign w_rd_addr    = (r_state == ST_DONE) ? w_start_addr : r_rd_ptr;
    assign w_issue      = w_rd_go | (~abort & (r_state == ST_READ) & (r_rd_cnt != DEPTH) & (w_occ < 2'd2));
    assign w_issue_last = (r_state == ST_READ) & (r_rd_cnt == DEPTH - CNT_ONE);
    assign w_push_idx   = r_q_cnt[0] ^ w_pop;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm)
                        w_state_next = (pre_depth == '0) ? ST_WAIT : ST_PRE;
                    else if (rd_start && r_state == ST_DONE)
                        w_state_next = ST_READ;
                end
                ST_PRE:  if (w_pre_next == {1'b0, pre_depth}) w_state_next = ST_WAIT;
                ST_WAIT: if (w_trig) w_state_next = (w_post_target == CNT_ONE) ? ST_DONE : ST_POST;
                ST_POST: if (sample_valid && w_post_next == w_post_target) w_state_next = ST_DONE;
                ST_READ: if (w_pop && rd_last) w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_trig_addr  <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_prev_match <= 1'b0;
            r_triggered  <= 1'b0;
        end else if (abort) begin
            r_triggered <= 1'b0;
        end else if (w_arm_ok) begin
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_prev_match <= 1'b1;
            r_triggered  <= 1'b0;
        end else begin
            if (sample_valid) r_prev_match <= w_match;
            if (w_we) r_wr_ptr <= r_wr_ptr + ADDR_ONE;
            if (r_state == ST_PRE) r_pre_cnt <= w_pre_next;
            if (r_state == ST_WAIT && w_trig) begin
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= CNT_ONE;
                r_triggered <= 1'b1;
            end
            if (r_state == ST_POST && sample_valid) r_post_cnt <= w_post_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_ram_vld   <= 1'b0;
            r_ram_last  <= 1'b0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_last    <= '0;
            r_q_cnt     <= '0;
        end else if (abort) begin
            r_ram_vld <= 1'b0;
            r_q_cnt   <= '0;
        end else begin
            r_ram_vld  <= w_issue;
            r_ram_last <= w_issue_last;
            if (w_issue) begin
                r_rd_ptr <= w_rd_addr + ADDR_ONE;
                r_rd_cnt <= (r_state == ST_DONE) ? CNT_ONE : r_rd_cnt + CNT_ONE;
            end
            if (w_pop) begin
                r_q_data[0] <= r_q_data[1];
                r_q_last[0] <= r_q_last[1];
            end
            if (r_ram_vld) begin
                r_q_data[w_push_idx] <= w_ram_rdata;
                r_q_last[w_push_idx] <= r_ram_last;
            end
            r_q_cnt <= w_occ;
        end
    end

    la_capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_wr_ptr),
        .i_wdata(sample_data),
        .i_re   (w_issue),
        .i_raddr(w_rd_addr),
        .o_rdata(w_ram_rdata)
    );

    assign rd_valid  = (r_q_cnt != 2'd0);
    assign rd_data   = r_q_data[0];
    assign rd_last   = rd_valid & r_q_last[0];
    assign state     = r_state;
    assign triggered = r_triggered;
    assign done      = (r_state == ST_DONE) || (r_state == ST_READ);
    assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_la_capture.sv
// tb/tb_la_capture.sv - self-checking bench for la_capture with a stream-level capture model
`timescale 1ns/1ps
module tb_la_capture;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_data, trig_mask, trig_value, rd_data;
    logic       sample_valid, arm, abort, trig_edge, rd_start, rd_ready;
    logic       rd_valid, rd_last, triggered, done;
    logic [3:0] pre_depth, trig_addr;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    logic [7:0] hist[$];
    int g_trig_i;
    int g_pre;

    always #5 clk = ~clk;

    la_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
        .trig_edge(trig_edge), .pre_depth(pre_depth), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .state(state),
        .triggered(triggered), .done(done), .trig_addr(trig_addr)
    );

    function automatic logic [7:0] gen_sample(input int mode, input int n);
        case (mode)
            0:       return 8'(n);
            2:       return (n < 5) ? 8'h55 : (n == 5) ? 8'h00 : 8'(8'h55 + n - 6);
            default: return 8'($urandom);
        endcase
    endfunction

    // Arms a capture and streams samples; the expected trigger is the first valid
    // sample at stream index >= pre that qualifies, and capture ends depth-pre samples later.
    task automatic run_capture(input int mode, input logic [7:0] mask, input logic [7:0] value,
                               input logic edge_m, input int pre, input int valid_pct,
                               input int budget, output bit ok);
        int n, trig_i, post_need;
        bit pm, mt, v, trig_seen, done_exp;
        logic [7:0] d;
        hist.delete();
        n = 0; pm = 1; trig_seen = 0; trig_i = -1; done_exp = 0; post_need = DEPTH - pre;
        trig_mask = mask; trig_value = value; trig_edge = edge_m; pre_depth = 4'(pre);
        sample_data = (mode == 2) ? 8'h55 : 8'h00; sample_valid = (mode == 2); arm = 1;
        @(negedge clk);
        arm = 0;
        for (int cyc = 0; cyc < budget && !done_exp; cyc++) begin
            v = ($urandom_range(99) < valid_pct);
            d = gen_sample(mode, n);
            sample_data = d; sample_valid = v;
            if (v) begin
                mt = ((d ^ value) & mask) == 8'h00;
                if (!trig_seen && n >= pre && mt && (!edge_m || !pm)) begin
                    trig_seen = 1; trig_i = n;
                end
                pm = mt; hist.push_back(d); n++;
                done_exp = trig_seen && (n == trig_i + post_need);
            end
            @(negedge clk);
            checks++;
            if (triggered !== trig_seen) begin
                errors++; $display("FAIL cap_triggered n=%0d got %b want %b", n, triggered, trig_seen);
            end
            checks++;
            if (done !== done_exp) begin
                errors++; $display("FAIL cap_done n=%0d got %b want %b", n, done, done_exp);
            end
        end
        sample_valid = 0;
        g_trig_i = trig_i; g_pre = pre; ok = done_exp;
        if (done_exp) begin
            checks++;
            if (trig_addr !== 4'(trig_i % DEPTH)) begin
                errors++; $display("FAIL cap_trig_addr got %0d want %0d", trig_addr, trig_i % DEPTH);
            end
        end else begin
            abort = 1; @(negedge clk); abort = 0;
        end
    endtask

    // ready_mode: 0 = always ready, 1 = alternating 1,0,..., 2 = random
    task automatic do_readout(input int ready_mode);
        int k, base;
        bit stalled;
        logic [7:0] prev_d;
        logic prev_l;
        k = 0; stalled = 0; base = g_trig_i - g_pre; prev_d = 0; prev_l = 0;
        rd_ready = 0; rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early got %b want 0", rd_valid); end
        @(negedge clk);
        for (int cyc = 2; cyc < 120 && k < DEPTH; cyc++) begin
            rd_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            sample_data = 8'($urandom); sample_valid = 1;
            if (cyc == 2 || ready_mode == 0) begin
                checks++;
                if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_gap cyc=%0d got %b want 1", cyc, rd_valid); end
            end
            if (stalled) begin
                checks++;
                if (rd_data !== prev_d || rd_last !== prev_l) begin
                    errors++; $display("FAIL rd_stall_hold got %h/%b want %h/%b", rd_data, rd_last, prev_d, prev_l);
                end
            end
            if (rd_valid === 1'b1) begin
                stalled = !rd_ready; prev_d = rd_data; prev_l = rd_last;
                if (rd_ready) begin
                    checks++;
                    if (rd_data !== hist[base + k]) begin
                        errors++; $display("FAIL rd_data k=%0d got %h want %h", k, rd_data, hist[base + k]);
                    end
                    checks++;
                    if (rd_last !== (k == DEPTH - 1)) begin
                        errors++; $display("FAIL rd_last k=%0d got %b want %b", k, rd_last, (k == DEPTH - 1));
                    end
                    k++;
                end
            end else begin
                stalled = 0;
            end
            @(negedge clk);
        end
        rd_ready = 0; sample_valid = 0;
        checks++;
        if (k != DEPTH) begin errors++; $display("FAIL rd_timeout got %0d words want %0d", k, DEPTH); end
        checks++;
        if (rd_valid !== 1'b0 || state !== 3'd4) begin
            errors++; $display("FAIL rd_end got valid=%b state=%0d want 0/4", rd_valid, state);
        end
    endtask

    task automatic test_reset();
        rst = 1; arm = 0; abort = 0; rd_start = 0; rd_ready = 0; sample_valid = 0; sample_data = 0;
        trig_mask = 0; trig_value = 0; trig_edge = 0; pre_depth = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || triggered !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got state=%0d done=%b trig=%b want 0", state, done, triggered);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00 || trig_addr !== 4'h0) begin
            errors++; $display("FAIL reset_data got %b %b %h %h want 0", rd_valid, rd_last, rd_data, trig_addr);
        end
    endtask

    task automatic test_level_trigger();
        bit ok;
        run_capture(0, 8'hFF, 8'hA5, 1'b0, 4, 100, 400, ok);
        checks++;
        if (trig_addr !== 4'd5) begin errors++; $display("FAIL level_trig_addr got %0d want 5", trig_addr); end
        do_readout(1);
        do_readout(0);
    endtask

    task automatic test_wrap_trigger();
        bit ok;
        run_capture(0, 8'hFF, 8'h02, 1'b0, 4, 100, 400, ok);
        checks++;
        if (trig_addr !== 4'd2) begin errors++; $display("FAIL wrap_trig_addr got %0d want 2", trig_addr); end
        do_readout(0);
    endtask

    task automatic test_edge_trigger();
        bit ok;
        run_capture(2, 8'hFF, 8'h55, 1'b1, 0, 100, 64, ok);
        checks++;
        if (trig_addr !== 4'd6) begin errors++; $display("FAIL edge_trig_addr got %0d want 6", trig_addr); end
        do_readout(2);
    endtask

    task automatic test_zero_pre();
        bit ok;
        run_capture(0, 8'hFF, 8'h00, 1'b0, 0, 100, 64, ok);
        checks++;
        if (trig_addr !== 4'd0) begin errors++; $display("FAIL zero_pre_trig_addr got %0d want 0", trig_addr); end
        do_readout(0);
    endtask

    task automatic test_full_pre();
        bit ok;
        run_capture(0, 8'hFF, 8'h20, 1'b0, 15, 100, 100, ok);
        do_readout(2);
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] m;
        for (int it = 0; it < 6; it++) begin
            m = 8'(1 << $urandom_range(7)) | 8'(1 << $urandom_range(7));
            run_capture(1, m, 8'($urandom), 1'($urandom_range(1)), int'($urandom_range(15)),
                        int'($urandom_range(100, 50)), 600, ok);
            if (ok) do_readout(2);
        end
    endtask

    task automatic test_abort_and_reset();
        bit ok;
        trig_mask = 8'hFF; trig_value = 8'h08; trig_edge = 0; pre_depth = 4'd2;
        sample_valid = 0; arm = 1;
        @(negedge clk);
        arm = 0;
        for (int n = 0; n < 11; n++) begin
            sample_data = 8'(n); sample_valid = 1;
            @(negedge clk);
        end
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL abort_pre_state got %0d want 3", state); end
        abort = 1; arm = 1;
        @(negedge clk);
        abort = 0; arm = 0; sample_valid = 0;
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_post got state=%0d done=%b want 0/0", state, done);
        end

        run_capture(0, 8'hFF, 8'h03, 1'b0, 0, 100, 64, ok);
        rd_ready = 0; rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd5 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL abort_read_pre got state=%0d valid=%b want 5/1", state, rd_valid);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if (state !== 3'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL abort_read got state=%0d valid=%b want 0/0", state, rd_valid);
        end

        run_capture(0, 8'hFF, 8'h03, 1'b0, 0, 100, 64, ok);
        rd_ready = 1; rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || triggered !== 1'b0 || trig_addr !== 4'h0) begin
            errors++; $display("FAIL async_rst_ctrl got %0d %b %b %h want 0", state, done, triggered, trig_addr);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL async_rst_data got %b %b %h want 0", rd_valid, rd_last, rd_data);
        end
        @(negedge clk);
        rst = 0; rd_ready = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_level_trigger();
        test_wrap_trigger();
        test_edge_trigger();
        test_zero_pre();
        test_full_pre();
        test_random();
        test_abort_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/la_capture.md
# la_capture

Parametrised logic-analyzer capture engine: a circular sample buffer with a programmable pre-trigger depth, a masked level/edge trigger, automatic post-trigger fill, and oldest-first readout over a valid/ready stream. It is the successor to the fixed 8-bit × 128K capture RAM. It sits between the probe-sampling front end and the host readout path. Buffer width, depth, trigger qualification and pre/post split are all run-time or build-time configurable.

## Interface
Parameters:
- DATA_WIDTH, 8: sample width in bits, 1..1152
- ADDR_WIDTH, 17: buffer depth is 2**ADDR_WIDTH samples, 4..20

Ports:
- clk  in  1  single clock for capture and readout
- rst  in  1  reset, asynchronous, active-high
- sample_data  in  DATA_WIDTH  probe sample
- sample_valid  in  1  sample qualifier; only valid samples are stored or counted
- arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE
- abort  in  1  forces IDLE from any state
- trig_mask  in  DATA_WIDTH  bits taking part in the compare
- trig_value  in  DATA_WIDTH  compare value
- trig_edge  in  1  0 = level match, 1 = rising-into-match
- pre_depth  in  ADDR_WIDTH  samples retained before the trigger, 0..2**ADDR_WIDTH-1
- rd_start  in  1  one-cycle pulse; starts readout from DONE
- rd_ready  in  1  readout sink ready
- rd_data  out  DATA_WIDTH  readout sample
- rd_valid  out  1  rd_data valid
- rd_last  out  1  marks the final (2**ADDR_WIDTH-th) readout word
- state  out  3  IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4, READ=5
- triggered  out  1  trigger seen in the current capture
- done  out  1  high in DONE and READ
- trig_addr  out  ADDR_WIDTH  buffer address holding the trigger sample

## Operation
- match = ((sample_data ^ trig_value) & trig_mask) == 0.
- Qualified trigger:
  - trig_edge = 0: valid & match.
  - trig_edge = 1: valid & match & !prev_match. prev_match updates on every valid sample and is set to 1 by arm, so a match already present at arm does not fire.
- arm: write pointer and counters clear to 0. arm is ignored in PRE, WAIT, POST and READ.
- PRE: each valid sample is written at wr_ptr, and wr_ptr increments (mod depth). Go to WAIT when pre_cnt == pre_depth; with pre_depth = 0, go to WAIT the cycle after arm. The trigger is ignored in PRE.
- WAIT: circular writing continues. A qualified trigger sample is written, trig_addr latches wr_ptr, post_cnt is set to 1, and the state goes to POST.
- POST: writing continues. When post_cnt reaches depth − pre_depth (trigger sample included), go to DONE. If pre_depth = depth−1, the trigger sample alone completes POST.
- DONE: writes stop. rd_start goes to READ.
- READ: reads depth words from start_addr = trig_addr − pre_depth (mod depth), incrementing and wrapping. After the word carrying rd_last is accepted, return to DONE; re-reading is allowed.
- Samples written in PRE before a wrap may be stale. Buffer contents are not cleared.
- abort wins over arm and rd_start in the same cycle. It drops any pending readout words (rd_valid = 0 the next cycle).
- Reset values: state = IDLE; rd_valid, rd_last, triggered, done = 0; rd_data and trig_addr = 0.

## Timing
- A sample is written on the clk edge where sample_valid = 1.
- triggered rises the cycle after the trigger sample edge.
- done rises the cycle after the final POST sample edge.
- RAM read latency is 1 cycle. The first rd_valid appears 2 cycles after rd_start.
- With rd_ready held high, throughput is 1 word/cycle with no bubbles. This requires a 2-entry output skid buffer.
- While rd_valid & !rd_ready, rd_data and rd_last hold stable.
- Counters are ADDR_WIDTH+1 bits so a full-depth post count does not overflow. All address arithmetic is mod 2**ADDR_WIDTH.
- pre_depth, trig_* are sampled continuously. They must be held stable from arm to DONE; behaviour is undefined if they change.

## Structure
- Shared package la_pkg holds: the state encoding constants, the trigger-mode constants (TRIG_LEVEL, TRIG_EDGE) and the depth function.
- One sub-module, la_capture_ram: simple dual-port RAM, DATA_WIDTH × 2**ADDR_WIDTH, single clock, unregistered output with 1-cycle read latency. The top level holds the FSM, counters, trigger logic and skid buffer.

## Test plan
Bench setup: DATA_WIDTH = 8, ADDR_WIDTH = 4 (depth 16). Stimulus is an incrementing 8-bit count starting at 0x00 on the cycle after arm, sample_valid = 1.

1. Level trigger, mask 0xFF, value 0xA5, pre_depth 4 -> trig_addr = 5; readout is 0xA1..0xB0 (16 words); rd_last on 0xB0.
2. Value 0x02, pre_depth 4 (match during PRE) -> ignored; fires on the wrapped 0x02 at sample 258; trig_addr = 2; readout is 0xFE, 0xFF, 0x00..0x0D.
3. Edge mode, value 0x55, data held at 0x55 through arm and 5 cycles -> no trigger. Then 0x00, 0x55 -> triggered 1 cycle after the 0x55 edge.
4. pre_depth 0, value 0x00 -> trigger on the first sample; trig_addr = 0; readout 0x00..0x0F; done rises 16 samples after arm.
5. rd_ready pattern 1,0,1,0… -> exactly 16 words, no duplicates or drops, rd_data stable while stalled. Then rd_start again -> identical 16 words.
6. abort in POST -> state = IDLE next cycle, done = 0. rst asserted mid-READ -> all outputs at reset values immediately, not waiting for clk.
